mbus_sleep_scheduler: RTL and testbench

//  Decides when the MBus layer goes to sleep and drives SLEEP_REQ of the sleep controller.

---
 rtl/mbus_sleep_scheduler_pkg.sv | 23 ++
 rtl/mbus_sleep_scheduler_if.sv | 35 +++
 rtl/mbus_sleep_scheduler_rr_arbiter.sv | 30 +++
 rtl/mbus_sleep_scheduler.sv | 161 ++++++++++++++++
 tb/tb_mbus_sleep_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbus_sleep_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mbus_sleep_scheduler_pkg                                          |
// | Brief  : Shared isolation levels and scheduler state encoding for the      |
// |          MBus sleep scheduler slice.                                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mbus_sleep_scheduler_pkg;

  // Levels of MBC_ISOLATE as driven by the sleep controller
  localparam logic IO_HOLD    = 1'b1;
  localparam logic IO_RELEASE = 1'b0;

  // Scheduler FSM; the encoding is exported on SCHED_STATE for debug
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_REQUEST  = 2'd2,
    ST_SLEEPING = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/mbus_sleep_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mbus_sleep_scheduler_if                                           |
// | Brief  : Request/veto/bus-status inputs and sleep-controller handshake of  |
// |          the sleep scheduler.                                              |
// | Ports  : SRC_REQ, SRC_VETO, BUS_BUSY, MBC_ISOLATE  -> scheduler            |
// |          SLEEP_REQ, SRC_GNT, SLEEP_ABORT, SCHED_STATE <- scheduler         |
// |          master = scheduler side, slave = environment side                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface mbus_sleep_scheduler_if
  import mbus_sleep_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] SRC_REQ;
  logic [NUM_SRC-1:0] SRC_VETO;
  logic               BUS_BUSY;
  logic               MBC_ISOLATE;
  logic               SLEEP_REQ;
  logic [NUM_SRC-1:0] SRC_GNT;
  logic               SLEEP_ABORT;
  sched_state_t       SCHED_STATE;

  modport master (
    input  SRC_REQ, SRC_VETO, BUS_BUSY, MBC_ISOLATE,
    output SLEEP_REQ, SRC_GNT, SLEEP_ABORT, SCHED_STATE
  );

  modport slave (
    output SRC_REQ, SRC_VETO, BUS_BUSY, MBC_ISOLATE,
    input  SLEEP_REQ, SRC_GNT, SLEEP_ABORT, SCHED_STATE
  );
endinterface
`default_nettype wire

// File: rtl/mbus_sleep_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mbus_rr_arbiter                                                   |
// | Brief  : Combinational round-robin pick. Returns the one-hot of the first  |
// |          set request found searching upward from i_ptr with wrap.          |
// | Ports  : i_req  [NUM_SRC] request vector                                   |
// |          i_ptr  [PTR_W]   search start index (must be < NUM_SRC)           |
// |          o_gnt  [NUM_SRC] one-hot pick, 0 when no request                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mbus_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
) (
  input  wire logic [NUM_SRC-1:0] i_req,
  input  wire logic [PTR_W-1:0]   i_ptr,
  output logic      [NUM_SRC-1:0] o_gnt
);

  logic [NUM_SRC-1:0] w_rot;
  logic [NUM_SRC-1:0] w_rot_gnt;

  // Rotate so that bit 0 is the source at i_ptr, isolate the lowest set bit,
  // then rotate back. Doubling the vector turns the shifts into rotations.
  assign w_rot     = NUM_SRC'({i_req, i_req} >> i_ptr);
  assign w_rot_gnt = w_rot & (~w_rot + NUM_SRC'(1));
  assign o_gnt     = NUM_SRC'(({w_rot_gnt, w_rot_gnt} << i_ptr) >> NUM_SRC);

endmodule
`default_nettype wire

// File: rtl/mbus_sleep_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mbus_sleep_scheduler                                              |
// | Brief  : Decides when the MBus layer sleeps. Round-robin arbitration of    |
// |          per-source sleep requests, veto/busy qualification over           |
// |          IDLE_CYCLES quiet cycles, then tracks MBC_ISOLATE through the     |
// |          sleep/wake sequence.                                              |
// | Ports  : MBUS_CLKIN  clock (posedge)                                       |
// |          RESETn      asynchronous active-low reset                         |
// |          bus         mbus_sleep_scheduler_if.master                        |
// | Config : MBUS_SLEEP_AUTO_EN - autonomous sleep after AUTO_IDLE_CYCLES      |
// |          quiet idle cycles with no source requesting.                      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mbus_sleep_scheduler
  import mbus_sleep_scheduler_pkg::*;
#(
  parameter int NUM_SRC          = 4,
  parameter int IDLE_CYCLES      = 8,
  parameter int CNT_W            = 4,
  parameter int AUTO_IDLE_CYCLES = 64,
  parameter int AUTO_W           = 7
) (
  input  wire logic              MBUS_CLKIN,
  input  wire logic              RESETn,
  mbus_sleep_scheduler_if.master bus
);

  localparam int               PTR_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

  // Elaboration-time parameter sanity
  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("NUM_SRC must be >= 2");
  end
  if ((IDLE_CYCLES < 1) || ((IDLE_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_cnt_w
    $error("CNT_W cannot hold IDLE_CYCLES-1");
  end
  if ((AUTO_IDLE_CYCLES < 1) || ((AUTO_IDLE_CYCLES - 1) >= (1 << AUTO_W))) begin : g_bad_auto_w
    $error("AUTO_W cannot hold AUTO_IDLE_CYCLES-1");
  end

  sched_state_t       r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_SRC-1:0] r_gnt;
  logic               r_sleep_req;
  logic               r_abort;

  logic [NUM_SRC-1:0] w_pick;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_quiet;
  logic               w_hold_ok;

  // MBC_ISOLATE is sampled directly: the sleep controller launches it on
  // either edge and the half-cycle path is timed, so no synchroniser here.
  assign w_quiet   = ~|bus.SRC_VETO & ~bus.BUS_BUSY & (bus.MBC_ISOLATE == IO_RELEASE);
  assign w_hold_ok = |(bus.SRC_REQ & r_gnt);

  mbus_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req (bus.SRC_REQ),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  // Index of the granted source, used to advance the pointer after wake
  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_gnt[i]) w_gnt_idx = PTR_W'(i);
    end
  end

  assign w_next_ptr = (w_gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

`ifdef MBUS_SLEEP_AUTO_EN
  localparam logic [AUTO_W-1:0] c_AUTO_LAST = AUTO_W'(AUTO_IDLE_CYCLES - 1);
  logic [AUTO_W-1:0] r_auto_cnt;
  logic              w_auto_quiet;
  assign w_auto_quiet = (r_state == ST_IDLE) & ~|bus.SRC_REQ & w_quiet;
`endif

  always_ff @(posedge MBUS_CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_sleep_req <= 1'b0;
      r_abort     <= 1'b0;
`ifdef MBUS_SLEEP_AUTO_EN
      r_auto_cnt  <= '0;
`endif
    end else begin
      r_abort <= 1'b0;
`ifdef MBUS_SLEEP_AUTO_EN
      // Counts only consecutive quiet idle cycles with no requester
      if (w_auto_quiet && (r_auto_cnt != c_AUTO_LAST)) r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
      else                                             r_auto_cnt <= '0;
`endif
      case (r_state)
        ST_IDLE: begin
          // An isolated bus (power-up or wake in progress) is never quiet
          if (|bus.SRC_REQ && w_quiet) begin
            r_state <= ST_QUALIFY;
            r_gnt   <= w_pick;
            r_cnt   <= '0;
          end
`ifdef MBUS_SLEEP_AUTO_EN
          else if (w_auto_quiet && (r_auto_cnt == c_AUTO_LAST)) begin
            r_state     <= ST_REQUEST;
            r_sleep_req <= 1'b1;
          end
`endif
        end
        ST_QUALIFY: begin
          if (w_quiet && w_hold_ok) begin
            if (r_cnt == c_CNT_LAST) begin
              r_state     <= ST_REQUEST;
              r_sleep_req <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_abort <= 1'b1;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_REQUEST: begin
          // Committed: only the controller's isolate response moves us on
          if (bus.MBC_ISOLATE == IO_HOLD) begin
            r_sleep_req <= 1'b0;
            r_state     <= ST_SLEEPING;
          end
        end
        ST_SLEEPING: begin
          if (bus.MBC_ISOLATE == IO_RELEASE) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            // Autonomous sleeps carry no grant and leave fairness untouched
            if (|r_gnt) r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.SLEEP_REQ   = r_sleep_req;
  assign bus.SRC_GNT     = r_gnt;
  assign bus.SLEEP_ABORT = r_abort;
  assign bus.SCHED_STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mbus_sleep_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mbus_sleep_scheduler                                           |
// | Brief  : Self-checking bench for mbus_sleep_scheduler: directed vector     |
// |          table, hand-written multi-cycle sequences, and random traffic     |
// |          against a behavioural model with a sleep-controller model.        |
// | Config : MBUS_SLEEP_AUTO_EN selects the autonomous-sleep expectations.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mbus_sleep_scheduler;
  import mbus_sleep_scheduler_pkg::*;

  localparam int N     = 4;
  localparam int IDLE  = 8;
  localparam int AUTO  = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mbus_sleep_scheduler_if #(.NUM_SRC(N)) bus();

  mbus_sleep_scheduler #(
    .NUM_SRC(N), .IDLE_CYCLES(IDLE), .CNT_W(4), .AUTO_IDLE_CYCLES(AUTO), .AUTO_W(7)
  ) dut (
    .MBUS_CLKIN (clk),
    .RESETn     (rstn),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic s, input logic [3:0] g,
                           input logic a, input logic [1:0] st);
    chk({tag, ".sleep_req"}, 32'(bus.SLEEP_REQ), 32'(s));
    chk({tag, ".src_gnt"},   32'(bus.SRC_GNT),   32'(g));
    chk({tag, ".abort"},     32'(bus.SLEEP_ABORT), 32'(a));
    chk({tag, ".state"},     32'(bus.SCHED_STATE), 32'(st));
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] v, input logic b, input logic i);
    bus.SRC_REQ     = r;
    bus.SRC_VETO    = v;
    bus.BUS_BUSY    = b;
    bus.MBC_ISOLATE = i;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; leaves reset released at a negedge
  task automatic do_reset();
    rstn = 1'b0;
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    step();
    step();
    rstn = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_phase, m_gnt, m_cnt, m_ptr, m_auto;
  bit m_sleep, m_abort;

  task automatic model_reset();
    m_phase = 0; m_gnt = -1; m_cnt = 0; m_ptr = 0; m_auto = 0;
    m_sleep = 1'b0; m_abort = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int s;
      s = (p + k) % N;
      if (r[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [3:0] gnt_vec(input int g);
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  // Advances the model by one clock edge given the inputs sampled at it
  task automatic model_step(input logic [3:0] r, input logic [3:0] v, input logic b, input logic i);
    bit quiet, idle_quiet;
    quiet      = (v == 4'b0) && !b && (i == IO_RELEASE);
    idle_quiet = (m_phase == 0) && (r == 4'b0) && quiet;
    m_abort    = 1'b0;
`ifdef MBUS_SLEEP_AUTO_EN
    m_auto = idle_quiet ? m_auto + 1 : 0;
`else
    m_auto = 0;
`endif
    case (m_phase)
      0: begin
        if (r != 4'b0 && quiet) begin
          m_phase = 1; m_gnt = rr_pick(r, m_ptr); m_cnt = 0;
        end else if (idle_quiet && m_auto == AUTO) begin
          m_phase = 2; m_sleep = 1'b1; m_auto = 0;
        end
      end
      1: begin
        // m_cnt counts quiet checks after acceptance; the IDLE-th one commits
        if (quiet && r[m_gnt]) begin
          m_cnt++;
          if (m_cnt == IDLE) begin m_phase = 2; m_sleep = 1'b1; end
        end else begin
          m_abort = 1'b1; m_gnt = -1; m_cnt = 0; m_phase = 0;
        end
      end
      2: if (i == IO_HOLD) begin m_sleep = 1'b0; m_phase = 3; end
      default: if (i == IO_RELEASE) begin
        m_phase = 0;
        if (m_gnt >= 0) m_ptr = (m_gnt + 1) % N;
        m_gnt = -1;
      end
    endcase
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] veto;
    logic       busy;
    logic       iso;
    logic       e_sleep;
    logic [3:0] e_gnt;
    logic       e_abort;
    logic [1:0] e_state;
  } vec_t;

  vec_t tbl[16];

  logic [3:0] rr_exp[5];
  logic [3:0] cur_req;
  logic [3:0] cur_veto;
  logic       cur_busy;
  logic       cur_iso;
  int         ctl_cnt;
  bit         saw_sleep;

  initial begin
    //            req     veto    b     i     slp   gnt     ab    st
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[1]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[2]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[3]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[4]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[5]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[7]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1};
    tbl[8]  = '{4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[9]  = '{4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[11] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[12] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd1};
    tbl[13] = '{4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd1};
    tbl[14] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    drive(4'b0, 4'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset values
    rstn = 1'b0;
    step();
    check_out("reset", 1'b0, 4'b0000, 1'b0, 2'd0);
    rstn = 1'b1;

    // Table: abort at cnt=4, pointer unchanged, veto, isolate-in-idle, ignore others
    for (int v = 0; v < 16; v++) begin
      drive(tbl[v].req, tbl[v].veto, tbl[v].busy, tbl[v].iso);
      step();
      check_out($sformatf("tbl%0d", v), tbl[v].e_sleep, tbl[v].e_gnt, tbl[v].e_abort, tbl[v].e_state);
    end

    // Basic sleep/wake with latency
    do_reset();
    drive(4'b0010, 4'b0, 1'b0, 1'b0);
    step();
    check_out("basic.accept", 1'b0, 4'b0010, 1'b0, 2'd1);
    for (int j = 1; j < IDLE; j++) begin
      step();
      chk($sformatf("basic.qual%0d", j), 32'(bus.SLEEP_REQ), 32'd0);
    end
    step();
    check_out("basic.req", 1'b1, 4'b0010, 1'b0, 2'd2);
    drive(4'b0010, 4'b0, 1'b0, 1'b1);
    step();
    check_out("basic.sleep", 1'b0, 4'b0010, 1'b0, 2'd3);
    drive(4'b0010, 4'b0, 1'b0, 1'b0);
    step();
    check_out("basic.wake", 1'b0, 4'b0000, 1'b0, 2'd0);
    drive(4'b0000, 4'b0, 1'b0, 1'b0);

    // Round-robin over five sleep/wake cycles
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 4'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("rr%0d.gnt", c), 32'(bus.SRC_GNT), 32'(rr_exp[c]));
      repeat (IDLE) step();
      chk($sformatf("rr%0d.sleep_req", c), 32'(bus.SLEEP_REQ), 32'd1);
      drive(4'b1111, 4'b0, 1'b0, 1'b1);
      step();
      drive(4'b1111, 4'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("rr%0d.idle", c), 32'(bus.SCHED_STATE), 32'd0);
    end

    // Commit ignores veto/busy/drop; async reset drops SLEEP_REQ at once
    do_reset();
    drive(4'b0001, 4'b0, 1'b0, 1'b0);
    repeat (IDLE + 1) step();
    check_out("commit.enter", 1'b1, 4'b0001, 1'b0, 2'd2);
    drive(4'b0000, 4'b0100, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step();
      check_out($sformatf("commit.hold%0d", j), 1'b1, 4'b0001, 1'b0, 2'd2);
    end
    rstn = 1'b0;
    #1;
    check_out("commit.async_rst", 1'b0, 4'b0000, 1'b0, 2'd0);
    #1;
    rstn = 1'b1;
    drive(4'b0, 4'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Autonomous sleep
    do_reset();
`ifdef MBUS_SLEEP_AUTO_EN
    repeat (AUTO - 1) step();
    check_out("auto.before", 1'b0, 4'b0000, 1'b0, 2'd0);
    step();
    check_out("auto.fire", 1'b1, 4'b0000, 1'b0, 2'd2);
`else
    saw_sleep = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      step();
      if (bus.SLEEP_REQ !== 1'b0) saw_sleep = 1'b1;
    end
    chk("noauto.sleep_req", 32'(saw_sleep), 32'd0);
`endif

    // Random traffic against the model, isolate from a sleep-controller model
    do_reset();
    model_reset();
    cur_req = 4'b0; cur_veto = 4'b0; cur_busy = 1'b0; cur_iso = 1'b0; ctl_cnt = 0;
    for (int t = 0; t < 3000; t++) begin
      check_out("rand", m_sleep, gnt_vec(m_gnt), m_abort, 2'(m_phase));
      if ($urandom_range(0, 15) == 0) cur_req = 4'($urandom);
      cur_veto = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      cur_busy = ($urandom_range(0, 14) == 0);
      if (!cur_iso) begin
        if (m_sleep) begin
          if (ctl_cnt == 0) begin cur_iso = 1'b1; ctl_cnt = $urandom_range(2, 6); end
          else ctl_cnt--;
        end else begin
          ctl_cnt = $urandom_range(0, 2);
        end
      end else begin
        if (ctl_cnt == 0) cur_iso = 1'b0;
        else ctl_cnt--;
      end
      drive(cur_req, cur_veto, cur_busy, cur_iso);
      model_step(cur_req, cur_veto, cur_busy, cur_iso);
      step();
    end
    check_out("rand.end", m_sleep, gnt_vec(m_gnt), m_abort, 2'(m_phase));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
